multi_phase_die_pwm: RTL and testbench

- Parametrised successor to the two-leg dead-time pulse chain.
- Generates NUM_PH non-overlapping pulses in strict rotation: phase 0, 1, … NUM_PH-1, then back to 0.
- Each pulse is preceded by a dead-time window.
- Adds:
  - burst count, or continuous mode
  - per-rotation and end-of-burst strobes
  - operand latching
  - zero-length skip rules
- Drives gate-drive legs from the PWM top level, replacing hard-wired cascades of single-pulse blocks.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_dwell_cnt.sv | 36 +++
 rtl/multi_phase_die_pwm.sv | 226 ++++++++++++++++++++++
 tb/tb_multi_phase_die_pwm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-phase dead-time pulse generator.
// Latency: n/a (types, constants and an elaboration-time width helper only).
// Backpressure: n/a.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIE   = 2'd1,
        PULSE = 2'd2
    } state_t;

    localparam int NUM_PH_MAX = 16;

    // Width of a phase index able to address n phases (never below 1 bit).
    function automatic int ph_idx_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 8; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pwm_dwell_cnt.sv
// Dwell counter for one dead-time or active window; reloaded for every window.
// Latency: load takes effect on the next edge; expire is high during the last cycle of the window.
// Backpressure: none; clear has priority over load, load over counting.
//
// Ports: clk/rst_n clock and async active-low reset; clr forces the count to 0;
// load/load_val start a new window of load_val cycles; expire flags the final cycle.
// The caller never loads 0: zero-length windows are skipped before the load.
module pwm_dwell_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Counts load_val down to 1; a value of 0 means no window is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/multi_phase_die_pwm.sv
// NUM_PH-phase non-overlapping pulse generator: per phase a dead-time window then an active window, strict rotation, burst or continuous.
// Latency: start edge -> first dead-time cycle next clock; outputs, pulse_valid and burst_done are registered.
// Backpressure: none; once started it free-runs until the burst ends, io_en drops (continuous), pwm_dis aborts or io_rst clears.
//
// Ports: io_clk / io_rst (async, active low); io_en start / keep-running; pwm_dis synchronous abort;
// io_defaultLevel inactive level; die_period / pulse_period window lengths; burst_cnt rotations (0 = continuous);
// io_pulseOut phase outputs; pulse_valid end-of-rotation strobe; burst_done end-of-burst strobe; busy.
// Optional macro PWM_PHASE_MASK_EN adds phase_mask, latched with the periods; a masked phase keeps its timing but never goes active.
module multi_phase_die_pwm
    import pwm_pkg::*;
#(
    parameter int _RAM_WIDTH = 32,
    parameter int NUM_PH     = 2,
    parameter int BURST_W    = 16
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  io_en,
    input  logic                  pwm_dis,
    input  logic                  io_defaultLevel,
    input  logic [_RAM_WIDTH-1:0] die_period,
    input  logic [_RAM_WIDTH-1:0] pulse_period,
    input  logic [BURST_W-1:0]    burst_cnt,
`ifdef PWM_PHASE_MASK_EN
    input  logic [NUM_PH-1:0]     phase_mask,
`endif
    output logic [NUM_PH-1:0]     io_pulseOut,
    output logic                  pulse_valid,
    output logic                  burst_done,
    output logic                  busy
);

    localparam int PH_W = ph_idx_w(NUM_PH);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PH - 1);

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [BURST_W-1:0]      rot_q, rot_d, rot_inc;
    logic [_RAM_WIDTH-1:0]   die_q, pulse_q;
    logic [BURST_W-1:0]      burst_q;
    logic [NUM_PH-1:0]       active_q, active_d;
    logic                    pv_q, pv_d;
    logic                    bd_q, bd_d;
    logic [NUM_PH-1:0]       mask_n;
`ifdef PWM_PHASE_MASK_EN
    logic [NUM_PH-1:0]       mask_q;
`endif

    logic                    latch;
    logic                    enter;
    logic                    end_phase;
    logic [_RAM_WIDTH-1:0]   ent_die, ent_pulse;
    logic                    cnt_clr, cnt_load, cnt_expire;
    logic [_RAM_WIDTH-1:0]   cnt_val;

    pwm_dwell_cnt #(.W(_RAM_WIDTH)) u_dwell (
        .clk      (io_clk),
        .rst_n    (io_rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expire   (cnt_expire)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        rot_d     = rot_q;
        rot_inc   = rot_q + 1'b1;
        pv_d      = 1'b0;
        bd_d      = 1'b0;
        latch     = 1'b0;
        enter     = 1'b0;
        end_phase = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        ent_die   = die_q;
        ent_pulse = pulse_q;
        active_d  = '0;
        mask_n    = '1;

        case (state_q)
            IDLE: begin
                if (io_en) begin
                    latch   = 1'b1;
                    enter   = 1'b1;
                    phase_d = '0;
                    rot_d   = '0;
                end
            end
            DIE: begin
                if (cnt_expire) begin
                    if (pulse_q != '0) begin
                        state_d  = PULSE;
                        cnt_load = 1'b1;
                        cnt_val  = pulse_q;
                    end else begin
                        end_phase = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (cnt_expire) begin
                    end_phase = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        // End of a phase: step to the next phase or close the rotation in the same cycle.
        if (end_phase) begin
            if (phase_q != LAST_PH) begin
                phase_d = phase_q + 1'b1;
                enter   = 1'b1;
            end else begin
                pv_d  = 1'b1;
                rot_d = rot_inc;
                if (burst_q != '0) begin
                    if (rot_inc == burst_q) begin
                        bd_d    = 1'b1;
                        state_d = IDLE;
                        phase_d = '0;
                        rot_d   = '0;
                        cnt_clr = 1'b1;
                    end else begin
                        phase_d = '0;
                        enter   = 1'b1;
                    end
                end else if (io_en) begin
                    phase_d = '0;
                    latch   = 1'b1;
                    enter   = 1'b1;
                end else begin
                    state_d = IDLE;
                    phase_d = '0;
                    rot_d   = '0;
                    cnt_clr = 1'b1;
                end
            end
        end

        // A latch point starts the phase from the live inputs, otherwise from the held copies.
        if (latch) begin
            ent_die   = die_period;
            ent_pulse = pulse_period;
        end

        // Phase entry with zero-length skips; both zero still costs one inactive dwell cycle.
        if (enter) begin
            cnt_load = 1'b1;
            if (ent_die != '0) begin
                state_d = DIE;
                cnt_val = ent_die;
            end else if (ent_pulse != '0) begin
                state_d = PULSE;
                cnt_val = ent_pulse;
            end else begin
                state_d = DIE;
                cnt_val = _RAM_WIDTH'(1);
            end
        end

        // Abort beats everything, including an end-of-rotation in the same cycle.
        if (pwm_dis) begin
            state_d  = IDLE;
            phase_d  = '0;
            rot_d    = '0;
            latch    = 1'b0;
            pv_d     = 1'b0;
            bd_d     = 1'b0;
            cnt_load = 1'b0;
            cnt_clr  = 1'b1;
        end

`ifdef PWM_PHASE_MASK_EN
        mask_n = latch ? phase_mask : mask_q;
`endif

        if (state_d == PULSE) begin
            active_d[phase_d] = mask_n[phase_d];
        end
    end

    always_ff @(posedge io_clk or negedge io_rst) begin
        if (!io_rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            rot_q    <= '0;
            die_q    <= '0;
            pulse_q  <= '0;
            burst_q  <= '0;
            active_q <= '0;
            pv_q     <= 1'b0;
            bd_q     <= 1'b0;
`ifdef PWM_PHASE_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            rot_q    <= rot_d;
            active_q <= active_d;
            pv_q     <= pv_d;
            bd_q     <= bd_d;
            if (latch) begin
                die_q   <= die_period;
                pulse_q <= pulse_period;
                burst_q <= burst_cnt;
`ifdef PWM_PHASE_MASK_EN
                mask_q  <= phase_mask;
`endif
            end
        end
    end

    assign io_pulseOut = active_q ^ {NUM_PH{io_defaultLevel}};
    assign pulse_valid = pv_q;
    assign burst_done  = bd_q;
    // The strobe cycle after the final rotation still counts as busy.
    assign busy        = (state_q != IDLE) | pv_q;

endmodule

// File: tb/tb_multi_phase_die_pwm.sv
// Bench for multi_phase_die_pwm: a 2-phase and a 4-phase instance, driven from a vector table.
// Latency: n/a.
// Backpressure: n/a.
module tb_multi_phase_die_pwm;

    logic        clk = 1'b0;
    logic        rst_n, en, dis, dflt, sel4;
    logic [31:0] die, pulse;
    logic [15:0] burst;
    logic [1:0]  out2;
    logic [3:0]  out4;
    logic        pv2, bd2, busy2, pv4, bd4, busy4;
`ifdef PWM_PHASE_MASK_EN
    logic [1:0]  mask2 = '1;
    logic [3:0]  mask4 = '1;
`endif

    always #5 clk = ~clk;

    multi_phase_die_pwm #(._RAM_WIDTH(32), .NUM_PH(2), .BURST_W(16)) dut2 (
        .io_clk(clk), .io_rst(rst_n), .io_en(en & ~sel4), .pwm_dis(dis),
        .io_defaultLevel(dflt), .die_period(die), .pulse_period(pulse), .burst_cnt(burst),
`ifdef PWM_PHASE_MASK_EN
        .phase_mask(mask2),
`endif
        .io_pulseOut(out2), .pulse_valid(pv2), .burst_done(bd2), .busy(busy2)
    );

    multi_phase_die_pwm #(._RAM_WIDTH(32), .NUM_PH(4), .BURST_W(16)) dut4 (
        .io_clk(clk), .io_rst(rst_n), .io_en(en & sel4), .pwm_dis(dis),
        .io_defaultLevel(dflt), .die_period(die), .pulse_period(pulse), .burst_cnt(burst),
`ifdef PWM_PHASE_MASK_EN
        .phase_mask(mask4),
`endif
        .io_pulseOut(out4), .pulse_valid(pv4), .burst_done(bd4), .busy(busy4)
    );

    typedef struct {
        bit    sel4;
        int    die, pulse, burst;
        bit    dflt;
        int    rots;
        int    en_drop, dis_cyc, rst_cyc, chg_cyc, ncyc;
        int    exp_act, exp_pv, exp_bd;
        string name;
    } vec_t;

    typedef struct packed {
        logic [3:0] act;
        logic       pv;
        logic       bd;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    vec_t vt[9];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, got, want);
        end
    endtask

    // Active pattern (output level relative to the default), strobes and busy of the selected instance.
    function automatic exp_t mon(input bit s4, input bit d);
        exp_t m;
        if (s4) begin
            m.act = out4 ^ {4{d}};
            m.pv = pv4; m.bd = bd4; m.busy = busy4;
        end else begin
            m.act = {2'b00, out2 ^ {2{d}}};
            m.pv = pv2; m.bd = bd2; m.busy = busy2;
        end
        return m;
    endfunction

    function automatic vec_t mk(input bit s4, input int d, input int p, input int b, input bit lv,
                                input int rots, input int edrop, input int dcyc, input int rcyc,
                                input int ccyc, input int n, input int ea, input int ep, input int eb,
                                input string nm);
        vec_t v;
        v.sel4 = s4; v.die = d; v.pulse = p; v.burst = b; v.dflt = lv; v.rots = rots;
        v.en_drop = edrop; v.dis_cyc = dcyc; v.rst_cyc = rcyc; v.chg_cyc = ccyc; v.ncyc = n;
        v.exp_act = ea; v.exp_pv = ep; v.exp_bd = eb; v.name = nm;
        return v;
    endfunction

    // Expected per-cycle trace from phase lengths: die idle cycles, then pulse active cycles,
    // one idle dwell when both are zero; the strobe lands on the first cycle after each rotation.
    task automatic gen(input vec_t v);
        exp_t tr[$];
        exp_t e;
        exp_t idle;
        bit   pend;
        int   nph;
        int   cut;
        nph  = v.sel4 ? 4 : 2;
        idle = '0;
        pend = 1'b0;
        for (int r = 0; r < v.rots; r++) begin
            for (int p = 0; p < nph; p++) begin
                if (v.die == 0 && v.pulse == 0) begin
                    e = '0; e.busy = 1'b1; e.pv = pend; pend = 1'b0; tr.push_back(e);
                end else begin
                    for (int k = 0; k < v.die; k++) begin
                        e = '0; e.busy = 1'b1; e.pv = pend; pend = 1'b0; tr.push_back(e);
                    end
                    for (int k = 0; k < v.pulse; k++) begin
                        e = '0; e.busy = 1'b1; e.act = 4'(1 << p); e.pv = pend; pend = 1'b0;
                        tr.push_back(e);
                    end
                end
            end
            pend = 1'b1;
        end
        e = '0; e.busy = 1'b1; e.pv = 1'b1; e.bd = (v.burst != 0); tr.push_back(e);
        cut = 1 << 30;
        if (v.dis_cyc > 0) cut = v.dis_cyc;
        if (v.rst_cyc > 0 && v.rst_cyc < cut) cut = v.rst_cyc;
        for (int i = 0; i < v.ncyc; i++) begin
            if (i < tr.size() && i < cut) sb.push_back(tr[i]);
            else sb.push_back(idle);
        end
    endtask

    task automatic run(input vec_t v);
        int   act_n, pv_n, bd_n;
        exp_t m, w;
        act_n = 0; pv_n = 0; bd_n = 0;
        @(negedge clk);
        die = 32'(v.die); pulse = 32'(v.pulse); burst = 16'(v.burst);
        dflt = v.dflt; sel4 = v.sel4; en = 1'b1;
        gen(v);
        for (int c = 1; c <= v.ncyc; c++) begin
            @(negedge clk);
            m = mon(v.sel4, v.dflt);
            if (m.act != 4'd0) act_n++;
            if (m.pv) pv_n++;
            if (m.bd) bd_n++;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL %s_cyc%0d scoreboard empty got=0x%0h", v.name, c, m);
            end else begin
                w = sb.pop_front();
                check($sformatf("%s_cyc%0d", v.name, c), 32'(m), 32'(w));
            end
            if (c == v.en_drop) en = 1'b0;
            if (c == v.chg_cyc) begin
                die = 32'd7; pulse = 32'd9; burst = 16'd1;
            end
            if (v.dis_cyc > 0 && c == v.dis_cyc) begin
                dis = 1'b1; en = 1'b0;
            end
            if (v.dis_cyc > 0 && c == v.dis_cyc + 1) dis = 1'b0;
            if (v.rst_cyc > 0 && c == v.rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check({v.name, "_rst_immediate"}, 32'(mon(v.sel4, v.dflt)), 32'd0);
            end
            if (v.rst_cyc > 0 && c == v.rst_cyc + 1) rst_n = 1'b1;
        end
        check({v.name, "_active_cycles"}, act_n, v.exp_act);
        check({v.name, "_pulse_valid_count"}, pv_n, v.exp_pv);
        check({v.name, "_burst_done_count"}, bd_n, v.exp_bd);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dis = 1'b0; dflt = 1'b0; sel4 = 1'b0;
        die = '0; pulse = '0; burst = '0;
        repeat (2) @(negedge clk);

        check("rst_out2", 32'(out2), 32'd0);
        check("rst_out4", 32'(out4), 32'd0);
        check("rst_flags2", 32'({pv2, bd2, busy2}), 32'd0);
        check("rst_flags4", 32'({pv4, bd4, busy4}), 32'd0);
        dflt = 1'b1;
        #1;
        check("rst_out4_dflt1", 32'(out4), 32'hf);
        check("rst_out2_dflt1", 32'(out2), 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        dflt = 1'b0;

        // A start request under pwm_dis never leaves IDLE.
        @(negedge clk);
        sel4 = 1'b1; en = 1'b1; dis = 1'b1; die = 32'd3; pulse = 32'd5; burst = 16'd1;
        repeat (3) @(negedge clk);
        check("dis_blocks_start_busy", 32'(busy4), 32'd0);
        check("dis_blocks_start_out", 32'(out4), 32'd0);
        en = 1'b0; dis = 1'b0;
        @(negedge clk);

        //        s4 die pul bur lv rots edrop dis rst chg  n  act pv bd
        vt[0] = mk(0, 3,  5,  1,  0, 1,   1,   0,  0,  0,  20, 10, 1, 1, "np2_d3_p5_b1");
        vt[1] = mk(1, 0,  2,  3,  0, 3,   1,   0,  0,  5,  27, 24, 3, 1, "np4_d0_p2_b3");
        vt[2] = mk(0, 2,  3,  0,  0, 2,   15,  0,  0,  0,  24, 12, 2, 0, "cont_en_drop");
        vt[3] = mk(0, 2,  10, 1,  0, 1,   1,   18, 0,  0,  22, 14, 0, 0, "abort_ph1");
        vt[4] = mk(1, 1,  0,  0,  1, 3,   10,  0,  0,  0,  16, 0,  3, 0, "dflt1_p0_cont");
        vt[5] = mk(0, 3,  5,  1,  0, 1,   1,   0,  6,  0,  10, 3,  0, 0, "async_rst");
        vt[6] = mk(0, 3,  5,  1,  0, 1,   1,   0,  0,  0,  20, 10, 1, 1, "restart");
        vt[7] = mk(1, 0,  0,  2,  0, 2,   1,   0,  0,  0,  12, 0,  2, 1, "both_zero");
        vt[8] = mk(1, 1,  1,  1,  1, 1,   1,   0,  0,  0,  12, 4,  1, 1, "dflt1_d1_p1");

        for (int i = 0; i < 9; i++) begin
            run(vt[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
